// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and defaults for the BFNP integer register file.
// Optional same-cycle write-to-read bypass is enabled by REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef logic [XLEN_DEF-1:0]          xword_t;
  typedef logic [$clog2(NREGS_DEF)-1:0] raddr_t;

  localparam raddr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: busy vector, outstanding-write counter and issue gate.
// Register 0 is never tracked and never counted.
import regfile_pkg::*;

module regfile_scoreboard #(
  parameter int NREGS    = NREGS_DEF,
  parameter int MAX_PEND = 4,
  parameter int ADDR_W   = $clog2(NREGS),
  parameter int CNT_W    = $clog2(MAX_PEND + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid_i,
  input  logic [ADDR_W-1:0] iss_rd_i,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_rd_i,
  input  logic              flush_i,
  output logic [NREGS-1:0]  busy_o,
  output logic              iss_ready_o,
  output logic [CNT_W-1:0]  pend_cnt_o
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PEND);
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             iss_cnt;
  logic             wb_cnt;

  always_comb begin
    iss_ready_o = (cnt_q < MAX_C) & ~flush_i;
    iss_cnt     = iss_valid_i & iss_ready_o
                & (iss_rd_i != ZERO_A);
    wb_cnt      = wb_valid_i & (wb_rd_i != ZERO_A);
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    if (flush_i) begin
      cnt_d  = '0;
      busy_d = '0;
    end else begin
      if (iss_cnt && !wb_cnt)
        cnt_d = cnt_q + 1'b1;
      else if (wb_cnt && !iss_cnt && cnt_q != '0)
        cnt_d = cnt_q - 1'b1;
      // issue after write-back: a new producer wins on the same rd
      if (wb_cnt)
        busy_d[wb_rd_i] = 1'b0;
      if (iss_cnt)
        busy_d[iss_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with RAW scoreboard and throttled issue.
// Define REGFILE_BYPASS_EN for zero-latency write-to-read forwarding.
import regfile_pkg::*;

module regfile_sb #(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int MAX_PEND = 4,
  localparam int ADDR_W  = $clog2(NREGS),
  localparam int CNT_W   = $clog2(MAX_PEND + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  iss_valid,
  input  logic [ADDR_W-1:0]     iss_rd,
  output logic                  iss_ready,
  input  logic                  wb_valid,
  input  logic [ADDR_W-1:0]     wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush,
  output logic [CNT_W-1:0]      pend_cnt
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy;
  logic             wr_en;

  assign wr_en = wb_valid & (wb_rd != ZERO_A);

  // regs_q[0] is reset to zero and never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      regs_q <= '{default: '0};
    else if (wr_en)
      regs_q[wb_rd] <= wb_data;
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .MAX_PEND (MAX_PEND),
    .ADDR_W   (ADDR_W),
    .CNT_W    (CNT_W)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .iss_valid_i (iss_valid),
    .iss_rd_i    (iss_rd),
    .wb_valid_i  (wb_valid),
    .wb_rd_i     (wb_rd),
    .flush_i     (flush),
    .busy_o      (busy),
    .iss_ready_o (iss_ready),
    .pend_cnt_o  (pend_cnt)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit = wr_en & ~rst & (wb_rd == a);
    assign rd_data[i*XLEN +: XLEN] = hit ? wb_data : regs_q[a];
    assign rd_busy[i] = busy[a] & ~hit;
`else
    assign rd_data[i*XLEN +: XLEN] = regs_q[a];
    assign rd_busy[i] = busy[a];
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and randomized checks of regfile_sb against
// an array/counter model of the architectural register file rules.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic [2:0]  pend_cnt;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mreg [32];
  bit          mbusy [32];
  int          mcnt;

  regfile_sb dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .flush     (flush),
    .pend_cnt  (pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      mreg[r]  = '0;
      mbusy[r] = 0;
    end
    mcnt = 0;
  endtask

  function automatic bit m_ready();
    return (mcnt < 4) && !flush;
  endfunction

  function automatic logic [31:0] m_data(int a);
`ifdef REGFILE_BYPASS_EN
    if (wb_valid && int'(wb_rd) == a && a != 0) return wb_data;
`endif
    return mreg[a];
  endfunction

  function automatic bit m_busy(int a);
`ifdef REGFILE_BYPASS_EN
    if (wb_valid && int'(wb_rd) == a && a != 0) return 0;
`endif
    return mbusy[a];
  endfunction

  // Apply one clock edge to both DUT and model with the current inputs.
  task automatic tick();
    bit fire, inc, dec;
    fire = iss_valid && m_ready();
    inc  = fire && iss_rd != 0;
    dec  = wb_valid && wb_rd != 0;
    @(posedge clk);
    if (dec) mreg[wb_rd] = wb_data;
    if (flush) begin
      for (int r = 0; r < 32; r++) mbusy[r] = 0;
      mcnt = 0;
    end else begin
      if (dec) mbusy[wb_rd] = 0;
      if (inc) mbusy[iss_rd] = 1;
      if (inc && !dec) mcnt++;
      else if (dec && !inc && mcnt > 0) mcnt--;
    end
    #1;
  endtask

  task automatic idle();
    iss_valid = 0;
    iss_rd    = '0;
    wb_valid  = 0;
    wb_rd     = '0;
    wb_data   = '0;
    flush     = 0;
  endtask

  task automatic test_reset();
    idle();
    rd_addr = {5'd5, 5'd5};
    @(posedge clk);
    #1;
    model_reset();
    rst = 0;
    #1;
    n_chk++;
    if (rd_data !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data got=%h exp=0", rd_data);
    end
    n_chk++;
    if (rd_busy !== 2'b00 || iss_ready !== 1'b1 || pend_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_ctl got busy=%b rdy=%b cnt=%0d exp 00/1/0",
               rd_busy, iss_ready, pend_cnt);
    end
  endtask

  task automatic test_raw();
    logic [31:0] ed;
    logic eb;
    rd_addr = {5'd0, 5'd3};
    iss_valid = 1; iss_rd = 5'd3;
    tick();
    idle();
    #1;
    n_chk++;
    if (rd_busy[0] !== 1'b1 || pend_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL raw_c2 got busy=%b cnt=%0d exp 1/1", rd_busy[0], pend_cnt);
    end
    tick();
    wb_valid = 1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
    #1;
`ifdef REGFILE_BYPASS_EN
    ed = 32'hDEADBEEF; eb = 0;
`else
    ed = 32'h0; eb = 1;
`endif
    n_chk++;
    if (rd_data[31:0] !== ed || rd_busy[0] !== eb) begin
      n_fail++;
      $display("FAIL raw_c3 got d=%h b=%b exp d=%h b=%b",
               rd_data[31:0], rd_busy[0], ed, eb);
    end
    tick();
    idle();
    #1;
    n_chk++;
    if (rd_data[31:0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0 || pend_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL raw_c4 got d=%h b=%b cnt=%0d exp deadbeef/0/0",
               rd_data[31:0], rd_busy[0], pend_cnt);
    end
  endtask

  task automatic test_zero_reg();
    rd_addr = {5'd0, 5'd0};
    wb_valid = 1; wb_rd = 5'd0; wb_data = 32'h12345678;
    iss_valid = 1; iss_rd = 5'd0;
    #1;
    n_chk++;
    if (rd_data !== 64'h0) begin
      n_fail++;
      $display("FAIL zero_same got=%h exp=0", rd_data);
    end
    tick();
    idle();
    #1;
    n_chk++;
    if (rd_data !== 64'h0 || rd_busy !== 2'b00 || pend_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL zero_after got d=%h b=%b cnt=%0d exp 0/00/0",
               rd_data, rd_busy, pend_cnt);
    end
  endtask

  task automatic test_max_pend();
    rd_addr = {5'd5, 5'd1};
    for (int r = 1; r <= 4; r++) begin
      iss_valid = 1; iss_rd = 5'(r);
      tick();
    end
    idle();
    #1;
    n_chk++;
    if (iss_ready !== 1'b0 || pend_cnt !== 3'd4) begin
      n_fail++;
      $display("FAIL full got rdy=%b cnt=%0d exp 0/4", iss_ready, pend_cnt);
    end
    iss_valid = 1; iss_rd = 5'd5;
    tick();
    idle();
    #1;
    n_chk++;
    if (pend_cnt !== 3'd4 || rd_busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL full_reject got cnt=%0d b5=%b exp 4/0", pend_cnt, rd_busy[1]);
    end
    wb_valid = 1; wb_rd = 5'd1; wb_data = 32'h0BADF00D;
    tick();
    idle();
    #1;
    n_chk++;
    if (pend_cnt !== 3'd3 || iss_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drain got cnt=%0d rdy=%b exp 3/1", pend_cnt, iss_ready);
    end
    for (int r = 2; r <= 4; r++) begin
      wb_valid = 1; wb_rd = 5'(r); wb_data = 32'(r * 16);
      tick();
    end
    idle();
  endtask

  task automatic test_same_cycle();
    rd_addr = {5'd0, 5'd7};
    iss_valid = 1; iss_rd = 5'd7;
    wb_valid = 1; wb_rd = 5'd7; wb_data = 32'h55;
    tick();
    idle();
    #1;
    n_chk++;
    if (rd_data[31:0] !== 32'h55 || rd_busy[0] !== 1'b1 || pend_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL same_cycle got d=%h b=%b cnt=%0d exp 55/1/0",
               rd_data[31:0], rd_busy[0], pend_cnt);
    end
  endtask

  task automatic test_flush();
    rd_addr = {5'd5, 5'd2};
    for (int k = 0; k < 3; k++) begin
      iss_valid = 1; iss_rd = (k == 0) ? 5'd2 : (k == 1) ? 5'd5 : 5'd6;
      tick();
    end
    flush = 1; iss_valid = 1; iss_rd = 5'd9;
    wb_valid = 1; wb_rd = 5'd2; wb_data = 32'hAA;
    #1;
    n_chk++;
    if (iss_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready got=%b exp=0", iss_ready);
    end
    tick();
    idle();
    rd_addr = {5'd7, 5'd2};
    #1;
    n_chk++;
    if (pend_cnt !== 3'd0 || rd_busy !== 2'b00 || rd_data[31:0] !== 32'hAA) begin
      n_fail++;
      $display("FAIL flush_after got cnt=%0d b=%b d=%h exp 0/00/aa",
               pend_cnt, rd_busy, rd_data[31:0]);
    end
  endtask

  task automatic test_random();
    int a0, a1;
    for (int c = 0; c < 400; c++) begin
      a0 = $urandom_range(0, 31);
      a1 = $urandom_range(0, 31);
      rd_addr   = {5'(a1), 5'(a0)};
      iss_valid = ($urandom_range(0, 2) != 0);
      iss_rd    = 5'($urandom_range(0, 15));
      wb_valid  = ($urandom_range(0, 2) == 0);
      wb_rd     = 5'($urandom_range(0, 15));
      wb_data   = $urandom;
      flush     = ($urandom_range(0, 19) == 0);
      #1;
      n_chk++;
      if (rd_data[31:0] !== m_data(a0) || rd_data[63:32] !== m_data(a1)
          || rd_busy !== {m_busy(a1), m_busy(a0)}
          || iss_ready !== m_ready() || pend_cnt !== 3'(mcnt)) begin
        n_fail++;
        $display("FAIL rand c=%0d got d=%h b=%b r=%b n=%0d exp d=%h%h b=%b%b r=%b n=%0d",
                 c, rd_data, rd_busy, iss_ready, pend_cnt, m_data(a1), m_data(a0),
                 m_busy(a1), m_busy(a0), m_ready(), mcnt);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    iss_valid = 1; iss_rd = 5'd4;
    tick();
    iss_valid = 1; iss_rd = 5'd3;
    wb_valid = 1; wb_rd = 5'd8; wb_data = 32'hCAFE;
    tick();
    rd_addr = {5'd8, 5'd3};
    iss_valid = 0;
    wb_valid = 1; wb_rd = 5'd3; wb_data = 32'h77;
    #1;
    rst = 1;
    #1;
    n_chk++;
    if (rd_data !== 64'h0 || rd_busy !== 2'b00 || iss_ready !== 1'b1 || pend_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_mid got d=%h b=%b r=%b n=%0d exp 0/00/1/0",
               rd_data, rd_busy, iss_ready, pend_cnt);
    end
    @(posedge clk);
    #1;
    idle();
    rst = 0;
    model_reset();
    #1;
    n_chk++;
    if (rd_data !== 64'h0 || pend_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_after got d=%h n=%0d exp 0/0", rd_data, pend_cnt);
    end
  endtask

  initial begin
    rst = 1;
    rd_addr = '0;
    idle();
    test_reset();
    test_raw();
    test_zero_reg();
    test_max_pend();
    test_same_cycle();
    test_flush();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised integer register file for the BFNP core.
- Configurable data width, register count and number of read ports.
- Integrated scoreboard tracks registers with in-flight writes; per-read-port busy flags let issue logic stall on RAW hazards.
- Issue-side valid/ready handshake is throttled by an outstanding-write counter.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of 2, at least 2). ADDR_W = $clog2(NREGS).
- NRD, 2, number of read ports (1..4).
- MAX_PEND, 4, maximum outstanding issued writes (1..NREGS-1). CNT_W = $clog2(MAX_PEND+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rd_addr  in  NRD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NRD*XLEN  read data, combinational.
- rd_busy  out  NRD  addressed register has a pending write not satisfied this cycle.
- iss_valid  in  1  issue of an instruction that will write iss_rd.
- iss_rd  in  ADDR_W  destination of the issuing instruction.
- iss_ready  out  1  scoreboard can accept an issue.
- wb_valid  in  1  write-back strobe.
- wb_rd  in  ADDR_W  write-back destination.
- wb_data  in  XLEN  write-back data.
- flush  in  1  discard all pending writes (pipeline flush).
- pend_cnt  out  CNT_W  current outstanding-write count.

Behaviour:
- Reset (asynchronous): all registers = 0, all busy bits = 0, pend_cnt = 0. Consequently iss_ready = 1, rd_busy = 0, rd_data = 0.
- Register 0 is hardwired to zero:
  - reads return 0;
  - writes are ignored;
  - it is never marked busy;
  - issue or write-back to it does not change pend_cnt.
- Write: on a rising edge with wb_valid and wb_rd != 0, reg[wb_rd] <= wb_data and busy[wb_rd] <= 0.
- Read: rd_data[i] = reg[rd_addr[i]], combinational, zero latency.
- rd_busy[i] = busy[rd_addr[i]], except as modified by the optional bypass feature below.
- Issue accept: iss_fire = iss_valid & iss_ready, where iss_ready = (pend_cnt < MAX_PEND) & ~flush.
  - On iss_fire with iss_rd != 0, busy[iss_rd] <= 1.
- Simultaneous issue and write-back to the same rd: busy ends at 1 (the new producer wins); the data write still occurs.
- Issue to an already-busy rd is legal (WAW):
  - busy stays 1;
  - pend_cnt increments;
  - the first write-back clears busy. The pipeline guarantees in-order write-back.
- pend_cnt next value:
  - +1 on a counted issue only;
  - -1 on a counted write-back only;
  - unchanged when both or neither occur.
  - A write-back with pend_cnt = 0 does not decrement (saturates at 0).
- flush:
  - on the next edge, all busy bits clear and pend_cnt <= 0;
  - a wb_valid in the same cycle still writes data;
  - iss_ready = 0 during the flush cycle.
- Reset asserted mid-operation overrides everything immediately, including a pending write in that cycle.
- Read and write addresses are full-range; there is no out-of-range case because NREGS = 2^ADDR_W.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - when wb_valid and wb_rd == rd_addr[i] != 0, rd_data[i] = wb_data and rd_busy[i] = 0 in the same cycle;
  - write-to-read latency is 0 cycles.
- Undefined:
  - rd_data returns the old value and rd_busy stays 1 until the edge after write-back;
  - write-to-read latency is 1 cycle.

Decomposition:
- Package regfile_pkg:
  - XLEN_DEF, NREGS_DEF;
  - typedef logic [XLEN_DEF-1:0] xword_t;
  - typedef logic [$clog2(NREGS_DEF)-1:0] raddr_t;
  - localparam raddr_t REG_ZERO = '0.
- Sub-module regfile_scoreboard:
  - contains the busy vector, pend_cnt, iss_ready and flush logic;
  - instantiated once;
  - the top level holds the storage array and the NRD read muxes generated by a for-generate loop.

Test Plan:
- Reset released, all rd_addr = 5 -> rd_data = 0, rd_busy = 0, iss_ready = 1, pend_cnt = 0.
- Issue rd = 3 at cycle 1, then wb rd = 3 data 0xDEADBEEF at cycle 3 -> rd_busy on port 0 (addr 3) is 1 during cycles 2-3. In cycle 3 with REGFILE_BYPASS_EN: rd_data = 0xDEADBEEF, rd_busy = 0. Without it: old data and busy = 1 until cycle 4. pend_cnt reads 1 then 0.
- Write 0x12345678 to rd = 0, issue rd = 0 -> rd_data for addr 0 stays 0, rd_busy = 0, pend_cnt unchanged.
- With MAX_PEND = 4, issue rd = 1, 2, 3, 4 on consecutive cycles -> iss_ready = 0 with pend_cnt = 4. A wb to rd = 1 drops pend_cnt to 3 and iss_ready returns to 1 the following cycle.
- Same-cycle issue and wb to rd = 7 with data 0x55 -> reg7 = 0x55, busy7 = 1, pend_cnt unchanged.
- 3 pending, flush together with wb rd = 2 data 0xAA -> next cycle pend_cnt = 0, all busy = 0, reg2 = 0xAA. Then assert rst mid-cycle -> all outputs return to reset values immediately.
